// File: rtl/crossbar_pkg.sv
// Shared crossbar definitions: default widths, command encoding and the
// per-slave arbiter state encoding.
package crossbar_pkg;

    localparam int DEFAULT_DATA_W = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin finder: returns the first requesting master found
// searching upward from the master after last_grant, wrapping around.
module rr_picker #(
    parameter int N_MASTERS = 2
) (
    input  logic [N_MASTERS-1:0]         req,
    input  logic [$clog2(N_MASTERS)-1:0] last_grant,
    output logic [$clog2(N_MASTERS)-1:0] winner,
    output logic                         any_req
);

    localparam int GW = $clog2(N_MASTERS);

    logic [GW-1:0] idx;

    // Walk candidates from farthest to nearest so the nearest requester
    // (lowest distance from last_grant) is the final assignment and wins.
    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = |req;
        for (int i = N_MASTERS; i >= 1; i--) begin
            idx = GW'((int'(last_grant) + i) % N_MASTERS);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/slave_port_arbiter.sv
// Per-slave arbitration stage: picks one master round-robin, holds it on the
// slave interface until ack, abort or timeout, and routes the response back.
module slave_port_arbiter
    import crossbar_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          req_from_master,
    input  logic [N_MASTERS*DATA_W-1:0]   addr_from_master,
    input  logic [N_MASTERS*DATA_W-1:0]   wdata_from_master,
    input  logic [N_MASTERS-1:0]          cmd_from_master,
    input  logic                          ack_from_slave_if,
    input  logic [DATA_W-1:0]             rdata_from_slave_if,
    output logic                          req_to_slave_if,
    output logic [DATA_W-1:0]             addr_to_slave_if,
    output logic [DATA_W-1:0]             wdata_to_slave_if,
    output logic                          cmd_to_slave_if,
    output logic                          connect_approved_to_slave_if,
    output logic [N_MASTERS-1:0]          ack_to_master,
    output logic [DATA_W-1:0]             rdata_to_master,
    output logic [N_MASTERS-1:0]          err_to_master,
    output logic [$clog2(N_MASTERS)-1:0]  grant_id
);

    localparam int GW    = $clog2(N_MASTERS);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_t             state;
    arb_state_t             next_state;
    logic [GW-1:0]          last_grant;
    logic [GW-1:0]          winner;
    logic                   any_req;
    logic [CNT_W-1:0]       timeout_cnt;
    logic [N_MASTERS-1:0]   err_q;
    logic                   leave_grant;
    logic                   timeout_hit;

    rr_picker #(
        .N_MASTERS (N_MASTERS)
    ) u_rr_picker (
        .req        (req_from_master),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign err_to_master = err_q;

    // State register; reset parks the arbiter in IDLE so outputs drop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, exit priority (ack > abort > timeout) and the slave/master muxing.
    always_comb begin
        next_state                   = state;
        leave_grant                  = 1'b0;
        timeout_hit                  = 1'b0;
        req_to_slave_if              = 1'b0;
        addr_to_slave_if             = '0;
        wdata_to_slave_if            = '0;
        cmd_to_slave_if              = CMD_READ;
        connect_approved_to_slave_if = 1'b0;
        ack_to_master                = '0;
        rdata_to_master              = '0;
        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    next_state = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                req_to_slave_if              = req_from_master[grant_id];
                addr_to_slave_if             = addr_from_master[grant_id*DATA_W +: DATA_W];
                wdata_to_slave_if            = wdata_from_master[grant_id*DATA_W +: DATA_W];
                cmd_to_slave_if              = cmd_from_master[grant_id];
                connect_approved_to_slave_if = 1'b1;
                ack_to_master[grant_id]      = ack_from_slave_if;
                rdata_to_master              = rdata_from_slave_if;
                if (ack_from_slave_if) begin
                    leave_grant = 1'b1;
                end else if (!req_from_master[grant_id]) begin
                    leave_grant = 1'b1;
                end else if ((TIMEOUT != 0) && (timeout_cnt == TIMEOUT_LAST)) begin
                    leave_grant = 1'b1;
                    timeout_hit = 1'b1;
                end
                if (leave_grant) begin
                    next_state = ARB_IDLE;
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    // Grant bookkeeping: capture the winner, age the transaction, raise the timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_id    <= GW'(N_MASTERS - 1);
            last_grant  <= GW'(N_MASTERS - 1);
            timeout_cnt <= '0;
            err_q       <= '0;
        end else begin
            err_q <= '0;
            if (state == ARB_IDLE) begin
                if (any_req) begin
                    grant_id    <= winner;
                    timeout_cnt <= '0;
                end
            end else begin
                if (leave_grant) begin
                    last_grant <= grant_id;
                    if (timeout_hit) begin
                        err_q[grant_id] <= 1'b1;
                    end
                end else if (timeout_cnt != CNT_MAX) begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Directed testbench for slave_port_arbiter with four masters and a short timeout.
module tb_slave_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_from_master;
    logic [N*DW-1:0]   addr_from_master;
    logic [N*DW-1:0]   wdata_from_master;
    logic [N-1:0]      cmd_from_master;
    logic              ack_from_slave_if;
    logic [DW-1:0]     rdata_from_slave_if;
    logic              req_to_slave_if;
    logic [DW-1:0]     addr_to_slave_if;
    logic [DW-1:0]     wdata_to_slave_if;
    logic              cmd_to_slave_if;
    logic              connect_approved_to_slave_if;
    logic [N-1:0]      ack_to_master;
    logic [DW-1:0]     rdata_to_master;
    logic [N-1:0]      err_to_master;
    logic [1:0]        grant_id;

    int checks = 0;
    int errors = 0;

    slave_port_arbiter #(
        .N_MASTERS (N),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .req_from_master              (req_from_master),
        .addr_from_master             (addr_from_master),
        .wdata_from_master            (wdata_from_master),
        .cmd_from_master              (cmd_from_master),
        .ack_from_slave_if            (ack_from_slave_if),
        .rdata_from_slave_if          (rdata_from_slave_if),
        .req_to_slave_if              (req_to_slave_if),
        .addr_to_slave_if             (addr_to_slave_if),
        .wdata_to_slave_if            (wdata_to_slave_if),
        .cmd_to_slave_if              (cmd_to_slave_if),
        .connect_approved_to_slave_if (connect_approved_to_slave_if),
        .ack_to_master                (ack_to_master),
        .rdata_to_master              (rdata_to_master),
        .err_to_master                (err_to_master),
        .grant_id                     (grant_id)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_master(input int m, input logic r, input logic [DW-1:0] a,
                              input logic [DW-1:0] d, input logic c);
        req_from_master[m]           = r;
        addr_from_master[m*DW +: DW]  = a;
        wdata_from_master[m*DW +: DW] = d;
        cmd_from_master[m]           = c;
    endtask

    task automatic test_reset();
        rst                 = 1'b1;
        req_from_master     = 4'b1111;
        addr_from_master    = {4{32'hA5A5_0001}};
        wdata_from_master   = {4{32'h1234_5678}};
        cmd_from_master     = 4'b1111;
        ack_from_slave_if   = 1'b1;
        rdata_from_slave_if = 32'hCAFE_F00D;
        step();
        step();
        checks++;
        if (connect_approved_to_slave_if !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_connect: got %b expected 0", connect_approved_to_slave_if);
        end
        checks++;
        if ({req_to_slave_if, cmd_to_slave_if, addr_to_slave_if, wdata_to_slave_if} !== 66'd0) begin
            errors++; $display("[TB] FAIL reset_slave_side: got req=%b cmd=%b addr=%h wdata=%h expected all 0",
                               req_to_slave_if, cmd_to_slave_if, addr_to_slave_if, wdata_to_slave_if);
        end
        checks++;
        if (ack_to_master !== 4'b0000 || err_to_master !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_ack_err: got ack=%b err=%b expected 0000/0000", ack_to_master, err_to_master);
        end
        checks++;
        if (grant_id !== 2'd3) begin
            errors++; $display("[TB] FAIL reset_grant_id: got %0d expected 3", grant_id);
        end
        req_from_master   = '0;
        cmd_from_master   = '0;
        addr_from_master  = '0;
        wdata_from_master = '0;
        ack_from_slave_if = 1'b0;
        rst = 1'b0;
        step();
        checks++;
        if (connect_approved_to_slave_if !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_no_req: got connect=%b expected 0", connect_approved_to_slave_if);
        end
    endtask

    task automatic test_single_read();
        set_master(0, 1'b1, 32'h10, 32'h0, 1'b0);
        settle();
        checks++;
        if (connect_approved_to_slave_if !== 1'b0) begin
            errors++; $display("[TB] FAIL read_no_early_connect: got %b expected 0", connect_approved_to_slave_if);
        end
        step();
        checks++;
        if (connect_approved_to_slave_if !== 1'b1 || grant_id !== 2'd0) begin
            errors++; $display("[TB] FAIL read_grant: got connect=%b gid=%0d expected 1/0", connect_approved_to_slave_if, grant_id);
        end
        checks++;
        if (addr_to_slave_if !== 32'h10 || cmd_to_slave_if !== 1'b0 || req_to_slave_if !== 1'b1) begin
            errors++; $display("[TB] FAIL read_slave_side: got addr=%h cmd=%b req=%b expected 10/0/1",
                               addr_to_slave_if, cmd_to_slave_if, req_to_slave_if);
        end
        step();
        checks++;
        if (ack_to_master !== 4'b0000 || connect_approved_to_slave_if !== 1'b1) begin
            errors++; $display("[TB] FAIL read_wait: got ack=%b connect=%b expected 0000/1", ack_to_master, connect_approved_to_slave_if);
        end
        step();
        ack_from_slave_if   = 1'b1;
        rdata_from_slave_if = 32'hDEAD_BEEF;
        settle();
        checks++;
        if (ack_to_master !== 4'b0001 || rdata_to_master !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL read_ack: got ack=%b rdata=%h expected 0001/deadbeef", ack_to_master, rdata_to_master);
        end
        step();
        ack_from_slave_if = 1'b0;
        set_master(0, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        checks++;
        if (connect_approved_to_slave_if !== 1'b0 || ack_to_master !== 4'b0000 || grant_id !== 2'd0) begin
            errors++; $display("[TB] FAIL read_back_idle: got connect=%b ack=%b gid=%0d expected 0/0000/0",
                               connect_approved_to_slave_if, ack_to_master, grant_id);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_gid;
        logic [3:0]  exp_ack;
        logic [31:0] exp_addr;
        rst = 1'b1;
        settle();
        rst = 1'b0;
        set_master(0, 1'b1, 32'h100, 32'h0, 1'b0);
        set_master(1, 1'b1, 32'h104, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            exp_gid  = 2'(k % 2);
            exp_ack  = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            exp_addr = (k % 2 == 0) ? 32'h100 : 32'h104;
            step();
            checks++;
            if (connect_approved_to_slave_if !== 1'b1 || grant_id !== exp_gid || addr_to_slave_if !== exp_addr) begin
                errors++; $display("[TB] FAIL rr_grant_%0d: got connect=%b gid=%0d addr=%h expected 1/%0d/%h",
                                   k, connect_approved_to_slave_if, grant_id, addr_to_slave_if, exp_gid, exp_addr);
            end
            ack_from_slave_if = 1'b1;
            settle();
            checks++;
            if (ack_to_master !== exp_ack) begin
                errors++; $display("[TB] FAIL rr_ack_%0d: got %b expected %b", k, ack_to_master, exp_ack);
            end
            step();
            ack_from_slave_if = 1'b0;
            settle();
            checks++;
            if (connect_approved_to_slave_if !== 1'b0) begin
                errors++; $display("[TB] FAIL rr_idle_gap_%0d: got connect=%b expected 0", k, connect_approved_to_slave_if);
            end
        end
        set_master(0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_master(1, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_write_routing();
        set_master(0, 1'b0, 32'h0BAD, 32'h0BAD, 1'b0);
        set_master(3, 1'b0, 32'h33, 32'h3333, 1'b0);
        set_master(2, 1'b1, 32'h20, 32'h55AA, 1'b1);
        step();
        checks++;
        if (grant_id !== 2'd2 || connect_approved_to_slave_if !== 1'b1) begin
            errors++; $display("[TB] FAIL wr_grant: got gid=%0d connect=%b expected 2/1", grant_id, connect_approved_to_slave_if);
        end
        checks++;
        if (wdata_to_slave_if !== 32'h55AA || addr_to_slave_if !== 32'h20 || cmd_to_slave_if !== 1'b1) begin
            errors++; $display("[TB] FAIL wr_slave_side: got wdata=%h addr=%h cmd=%b expected 55aa/20/1",
                               wdata_to_slave_if, addr_to_slave_if, cmd_to_slave_if);
        end
        ack_from_slave_if = 1'b1;
        settle();
        checks++;
        if (ack_to_master !== 4'b0100) begin
            errors++; $display("[TB] FAIL wr_ack: got %b expected 0100", ack_to_master);
        end
        step();
        ack_from_slave_if = 1'b0;
        set_master(0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_master(2, 1'b0, 32'h0, 32'h0, 1'b0);
        set_master(3, 1'b0, 32'h0, 32'h0, 1'b0);
        settle();
        checks++;
        if (connect_approved_to_slave_if !== 1'b0) begin
            errors++; $display("[TB] FAIL wr_back_idle: got connect=%b expected 0", connect_approved_to_slave_if);
        end
    endtask

    task automatic test_timeout();
        set_master(1, 1'b1, 32'h44, 32'h0, 1'b0);
        step();
        checks++;
        if (grant_id !== 2'd1 || connect_approved_to_slave_if !== 1'b1) begin
            errors++; $display("[TB] FAIL to_grant: got gid=%0d connect=%b expected 1/1", grant_id, connect_approved_to_slave_if);
        end
        set_master(0, 1'b1, 32'h48, 32'h0, 1'b0);
        for (int c = 1; c < TO; c++) begin
            step();
            checks++;
            if (connect_approved_to_slave_if !== 1'b1 || err_to_master !== 4'b0000) begin
                errors++; $display("[TB] FAIL to_hold_%0d: got connect=%b err=%b expected 1/0000",
                                   c, connect_approved_to_slave_if, err_to_master);
            end
        end
        step();
        checks++;
        if (err_to_master !== 4'b0010 || connect_approved_to_slave_if !== 1'b0) begin
            errors++; $display("[TB] FAIL to_err_pulse: got err=%b connect=%b expected 0010/0", err_to_master, connect_approved_to_slave_if);
        end
        set_master(1, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        checks++;
        if (err_to_master !== 4'b0000 || grant_id !== 2'd0 || connect_approved_to_slave_if !== 1'b1) begin
            errors++; $display("[TB] FAIL to_next_grant: got err=%b gid=%0d connect=%b expected 0000/0/1",
                               err_to_master, grant_id, connect_approved_to_slave_if);
        end
        ack_from_slave_if = 1'b1;
        step();
        ack_from_slave_if = 1'b0;
        set_master(0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_abort();
        set_master(0, 1'b1, 32'h80, 32'h0, 1'b0);
        step();
        checks++;
        if (grant_id !== 2'd0 || connect_approved_to_slave_if !== 1'b1) begin
            errors++; $display("[TB] FAIL ab_grant: got gid=%0d connect=%b expected 0/1", grant_id, connect_approved_to_slave_if);
        end
        step();
        set_master(0, 1'b0, 32'h80, 32'h0, 1'b0);
        step();
        checks++;
        if (connect_approved_to_slave_if !== 1'b0 || ack_to_master !== 4'b0000 || err_to_master !== 4'b0000) begin
            errors++; $display("[TB] FAIL ab_idle: got connect=%b ack=%b err=%b expected 0/0000/0000",
                               connect_approved_to_slave_if, ack_to_master, err_to_master);
        end
        ack_from_slave_if   = 1'b1;
        rdata_from_slave_if = 32'h1111_2222;
        settle();
        checks++;
        if (ack_to_master !== 4'b0000) begin
            errors++; $display("[TB] FAIL ab_late_ack: got %b expected 0000", ack_to_master);
        end
        step();
        checks++;
        if (connect_approved_to_slave_if !== 1'b0 || err_to_master !== 4'b0000 || grant_id !== 2'd0) begin
            errors++; $display("[TB] FAIL ab_stay_idle: got connect=%b err=%b gid=%0d expected 0/0000/0",
                               connect_approved_to_slave_if, err_to_master, grant_id);
        end
        ack_from_slave_if = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        set_master(1, 1'b1, 32'h90, 32'h9999, 1'b1);
        step();
        checks++;
        if (grant_id !== 2'd1 || connect_approved_to_slave_if !== 1'b1) begin
            errors++; $display("[TB] FAIL rmg_grant: got gid=%0d connect=%b expected 1/1", grant_id, connect_approved_to_slave_if);
        end
        ack_from_slave_if = 1'b1;
        rst = 1'b1;
        settle();
        checks++;
        if (connect_approved_to_slave_if !== 1'b0 || req_to_slave_if !== 1'b0 ||
            addr_to_slave_if !== 32'h0 || wdata_to_slave_if !== 32'h0 || cmd_to_slave_if !== 1'b0) begin
            errors++; $display("[TB] FAIL rmg_outputs: got connect=%b req=%b addr=%h wdata=%h cmd=%b expected all 0",
                               connect_approved_to_slave_if, req_to_slave_if, addr_to_slave_if, wdata_to_slave_if, cmd_to_slave_if);
        end
        checks++;
        if (ack_to_master !== 4'b0000 || err_to_master !== 4'b0000 || grant_id !== 2'd3) begin
            errors++; $display("[TB] FAIL rmg_ack_err_gid: got ack=%b err=%b gid=%0d expected 0000/0000/3",
                               ack_to_master, err_to_master, grant_id);
        end
        ack_from_slave_if = 1'b0;
        step();
        rst = 1'b0;
        set_master(0, 1'b1, 32'hA0, 32'h0, 1'b0);
        step();
        checks++;
        if (grant_id !== 2'd0 || connect_approved_to_slave_if !== 1'b1 || addr_to_slave_if !== 32'hA0) begin
            errors++; $display("[TB] FAIL rmg_priority: got gid=%0d connect=%b addr=%h expected 0/1/a0",
                               grant_id, connect_approved_to_slave_if, addr_to_slave_if);
        end
    endtask

    // Run each scenario in order, then report.
    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write_routing();
        test_timeout();
        test_abort();
        test_reset_mid_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
